// File: rtl/m_mem_ctrl_if.sv
// Data-memory bus between the M-stage controller and the memory.
// req/gnt request phase, then rvalid/rdata for loads.
interface m_mem_ctrl_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_gnt;
  logic        bus_rvalid;
  logic [31:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    input  bus_gnt, bus_rvalid, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    output bus_gnt, bus_rvalid, bus_rdata
  );
endinterface

// File: rtl/m_mem_ctrl.sv
// M-stage data-memory controller: decodes loads/stores from the E->M
// register, runs the req/gnt + rvalid handshake, extends load data and
// stalls the pipeline while an access is outstanding.
module m_mem_ctrl #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [31:0]  m_ir,
  input  logic [31:0]  m_ao,
  input  logic [31:0]  m_v2,
  input  logic         m_adv,
  m_mem_ctrl_if.master bus,
  output logic [31:0]  ld_data,
  output logic         ld_valid,
  output logic         stall,
  output logic         align_err,
  output logic         bus_err
);

  localparam int unsigned CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
  typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} size_t;

  state_t        state, state_nxt;
  size_t         op_size, lat_size;
  logic          is_load, is_store, op_signed, lat_signed;
  logic          mem_go;
  logic [1:0]    lat_lane;
  logic [3:0]    be_nxt;
  logic [31:0]   wdata_nxt;
  logic [31:0]   ld_ext;
  logic [7:0]    byte_sel;
  logic [15:0]   half_sel;
  logic [CW-1:0] wait_cnt;
  logic          fin, take_data, take_tmo;
  logic          unused_ir;

  assign unused_ir = ^m_ir[25:0];

  // Opcode decode: access size, direction and signedness.
  always_comb begin
    is_load   = 1'b0;
    is_store  = 1'b0;
    op_size   = SZ_WORD;
    op_signed = 1'b0;
    case (m_ir[31:26])
      6'h20: begin is_load  = 1'b1; op_size = SZ_BYTE; op_signed = 1'b1; end
      6'h21: begin is_load  = 1'b1; op_size = SZ_HALF; op_signed = 1'b1; end
      6'h23: begin is_load  = 1'b1; op_size = SZ_WORD; end
      6'h24: begin is_load  = 1'b1; op_size = SZ_BYTE; end
      6'h25: begin is_load  = 1'b1; op_size = SZ_HALF; end
      6'h28: begin is_store = 1'b1; op_size = SZ_BYTE; end
      6'h29: begin is_store = 1'b1; op_size = SZ_HALF; end
      6'h2B: begin is_store = 1'b1; op_size = SZ_WORD; end
      default: ;
    endcase
  end

  // Alignment check and lane generation for the request.
  always_comb begin
    align_err = (is_load || is_store) &&
                ((op_size == SZ_HALF && m_ao[0]) ||
                 (op_size == SZ_WORD && (m_ao[1:0] != 2'b00)));
    mem_go    = (is_load || is_store) && !align_err;
    be_nxt    = 4'b1111;
    wdata_nxt = m_v2;
    case (op_size)
      SZ_BYTE: begin
        be_nxt    = 4'b0001 << m_ao[1:0];
        wdata_nxt = {4{m_v2[7:0]}};
      end
      SZ_HALF: begin
        be_nxt    = m_ao[1] ? 4'b1100 : 4'b0011;
        wdata_nxt = {2{m_v2[15:0]}};
      end
      default: ;
    endcase
  end

  // State register; reset abandons any transaction in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state, stall and request strobe.
  // Completion drops stall in the same cycle, so the pipeline may advance on
  // the completing edge; DONE is skipped then because the next instruction
  // already occupies M and must be decoded in IDLE.
  always_comb begin
    state_nxt   = state;
    stall       = 1'b0;
    bus.bus_req = 1'b0;
    fin         = 1'b0;
    take_data   = 1'b0;
    take_tmo    = 1'b0;
    case (state)
      IDLE: begin
        if (mem_go) begin
          stall     = 1'b1;
          state_nxt = REQ;
        end
      end
      REQ: begin
        bus.bus_req = 1'b1;
        if (bus.bus_gnt) begin
          if (bus.bus_we) fin = 1'b1;
          else            state_nxt = WAIT;
        end
        stall = !(bus.bus_gnt && bus.bus_we);
      end
      WAIT: begin
        if (bus.bus_rvalid) begin
          take_data = 1'b1;
          fin       = 1'b1;
        end else if (wait_cnt == LAST) begin
          take_tmo = 1'b1;
          fin      = 1'b1;
        end
        stall = !fin;
      end
      DONE: begin
        if (m_adv) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (fin) state_nxt = m_adv ? IDLE : DONE;
  end

  // Request fields captured on issue so they stay stable until grant.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.bus_we    <= 1'b0;
      bus.bus_addr  <= '0;
      bus.bus_be    <= '0;
      bus.bus_wdata <= '0;
      lat_lane      <= '0;
      lat_size      <= SZ_WORD;
      lat_signed    <= 1'b0;
    end else if (state == IDLE && mem_go) begin
      bus.bus_we    <= is_store;
      bus.bus_addr  <= {m_ao[31:2], 2'b00};
      bus.bus_be    <= be_nxt;
      bus.bus_wdata <= wdata_nxt;
      lat_lane      <= m_ao[1:0];
      lat_size      <= op_size;
      lat_signed    <= op_signed;
    end
  end

  // Cycles spent in WAIT, for the rvalid timeout.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)              wait_cnt <= '0;
    else if (state == WAIT) wait_cnt <= wait_cnt + CW'(1);
    else                    wait_cnt <= '0;
  end

  // Lane select and sign/zero extension of the returned word.
  always_comb begin
    byte_sel = bus.bus_rdata[{lat_lane, 3'b000} +: 8];
    half_sel = lat_lane[1] ? bus.bus_rdata[31:16] : bus.bus_rdata[15:0];
    case (lat_size)
      SZ_BYTE: ld_ext = {{24{lat_signed & byte_sel[7]}}, byte_sel};
      SZ_HALF: ld_ext = {{16{lat_signed & half_sel[15]}}, half_sel};
      default: ld_ext = bus.bus_rdata;
    endcase
  end

  // Load result and error flags; held until the instruction retires.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ld_data  <= '0;
      ld_valid <= 1'b0;
      bus_err  <= 1'b0;
    end else if (take_data) begin
      ld_data  <= ld_ext;
      ld_valid <= 1'b1;
      bus_err  <= 1'b0;
    end else if (take_tmo) begin
      ld_data  <= '0;
      ld_valid <= 1'b0;
      bus_err  <= 1'b1;
    end else if ((state == DONE && m_adv) ||
                 (state == IDLE && (m_adv || mem_go))) begin
      ld_valid <= 1'b0;
      bus_err  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_m_mem_ctrl.sv
// Testbench for m_mem_ctrl: scoreboard of expected bus requests and load
// results, memory responder with programmable grant/rvalid delays.
module tb_m_mem_ctrl;

  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] m_ir = '0, m_ao = '0, m_v2 = '0;
  logic        pipe_we = 1'b1;
  logic        m_adv;
  logic [31:0] ld_data;
  logic        ld_valid, stall, align_err, bus_err;

  m_mem_ctrl_if bus();

  m_mem_ctrl #(.TIMEOUT(TMO)) dut (
    .clk       (clk),
    .reset     (reset),
    .m_ir      (m_ir),
    .m_ao      (m_ao),
    .m_v2      (m_v2),
    .m_adv     (m_adv),
    .bus       (bus),
    .ld_data   (ld_data),
    .ld_valid  (ld_valid),
    .stall     (stall),
    .align_err (align_err),
    .bus_err   (bus_err)
  );

  assign m_adv = pipe_we && !stall;

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } bus_exp_t;

  bus_exp_t    bus_q[$];
  logic [31:0] ld_q[$];
  int          n_chk = 0;
  int          n_fail = 0;
  logic        ld_prev = 1'b0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: bus requests and load results.
  always @(negedge clk) begin
    if (reset) begin
      ld_prev = 1'b0;
    end else begin
      if (bus.bus_req) begin
        if (bus_q.size() == 0) check("req_unexpected", 32'd1, 32'd0);
        else begin
          check("bus_we",    32'(bus.bus_we), 32'(bus_q[0].we));
          check("bus_addr",  bus.bus_addr,    bus_q[0].addr);
          check("bus_be",    32'(bus.bus_be), 32'(bus_q[0].be));
          check("bus_wdata", bus.bus_wdata,   bus_q[0].wdata);
          if (bus.bus_gnt) void'(bus_q.pop_front());
        end
      end
      if (ld_valid && !ld_prev) begin
        if (ld_q.size() == 0) check("ld_unexpected", 32'd1, 32'd0);
        else                  check("ld_data", ld_data, ld_q.pop_front());
      end
      ld_prev = ld_valid;
    end
  end

  // One M-stage instruction; called and returns at posedge+1.
  // r < 0 withholds rvalid; hold keeps pipe_we low for that many
  // stall-free cycles to exercise DONE.
  task automatic run_op(input logic [5:0] op, input logic [31:0] ao, input logic [31:0] v2,
                        input int g, input int r, input logic [31:0] rd, input int hold,
                        input logic [31:0] eld);
    logic ld, st, word, half, mis, issue, tmo, granted, adv;
    bus_exp_t e;
    int exp_stall, n_stall, req_n, wcnt, hold_cnt;
    ld   = op inside {6'h20, 6'h21, 6'h23, 6'h24, 6'h25};
    st   = op inside {6'h28, 6'h29, 6'h2B};
    word = op inside {6'h23, 6'h2B};
    half = op inside {6'h21, 6'h25, 6'h29};
    mis  = (half && ao[0]) || (word && ao[1:0] != 2'b00);
    issue = (ld || st) && !mis;
    tmo  = ld && (r < 0);
    e.we    = st;
    e.addr  = {ao[31:2], 2'b00};
    e.be    = word ? 4'hF : half ? (ao[1] ? 4'hC : 4'h3) : (4'b0001 << ao[1:0]);
    e.wdata = word ? v2 : half ? {2{v2[15:0]}} : {4{v2[7:0]}};
    if (issue) bus_q.push_back(e);
    if (issue && ld && !tmo) ld_q.push_back(eld);
    exp_stall = !issue ? 0 : st ? 1 + g : tmo ? 1 + g + TMO : 2 + g + r;
    n_stall = 0; req_n = 0; wcnt = 0; hold_cnt = 0; granted = 0; adv = 0;
    m_ir = {op, 26'($urandom)};
    m_ao = ao;
    m_v2 = v2;
    bus.bus_rdata = rd;
    for (int cyc = 0; cyc < 200; cyc++) begin
      pipe_we = (hold_cnt >= hold);
      bus.bus_gnt    = bus.bus_req && !granted && (req_n == g);
      bus.bus_rvalid = granted && ld && (r >= 0) && (wcnt == r);
      @(negedge clk);
      if (cyc == 0) check("align_err", 32'(align_err), 32'(mis));
      if (stall) n_stall++;
      else       hold_cnt++;
      if (granted) wcnt++;
      if (bus.bus_req) begin
        req_n++;
        if (bus.bus_gnt) begin granted = 1; wcnt = 0; end
      end
      adv = m_adv;
      @(posedge clk);
      #1;
      bus.bus_gnt = 1'b0;
      bus.bus_rvalid = 1'b0;
      if (adv) break;
    end
    pipe_we = 1'b1;
    check("advanced", 32'(adv), 32'd1);
    check("stall_cycles", 32'(n_stall), 32'(exp_stall));
    check("req_cycles", 32'(req_n), issue ? 32'(g + 1) : 32'd0);
    if (issue && ld) check("bus_err", 32'(bus_err), 32'(tmo));
    if (tmo) begin
      check("tmo_ld_data", ld_data, 32'd0);
      check("tmo_ld_valid", 32'(ld_valid), 32'd0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.bus_gnt = 1'b0;
    bus.bus_rvalid = 1'b0;
    bus.bus_rdata = '0;
    repeat (2) @(negedge clk);
    check("rst_stall",    32'(stall),       32'd0);
    check("rst_req",      32'(bus.bus_req), 32'd0);
    check("rst_ld_valid", 32'(ld_valid),    32'd0);
    check("rst_bus_err",  32'(bus_err),     32'd0);
    check("rst_ld_data",  ld_data,          32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    //     op     ao          v2            g  r     rdata         hold exp ld
    run_op(6'h2B, 32'h100, 32'hDEADBEEF, 0, 0,    32'h0,        0, 32'h0);
    run_op(6'h20, 32'h103, 32'h0,        0, 0,    32'h80FF1234, 0, 32'hFFFFFF80);
    run_op(6'h24, 32'h103, 32'h0,        0, 0,    32'h80FF1234, 0, 32'h00000080);
    run_op(6'h21, 32'h102, 32'h0,        0, 0,    32'h80017FFF, 0, 32'hFFFF8001);
    run_op(6'h25, 32'h102, 32'h0,        1, 1,    32'h80017FFF, 0, 32'h00008001);
    run_op(6'h21, 32'h100, 32'h0,        0, 2,    32'h80017FFF, 0, 32'h00007FFF);
    run_op(6'h29, 32'h102, 32'h1234ABCD, 0, 0,    32'h0,        0, 32'h0);
    run_op(6'h28, 32'h101, 32'h00000055, 2, 0,    32'h0,        0, 32'h0);
    run_op(6'h23, 32'h101, 32'h0,        0, 0,    32'h0,        0, 32'h0);
    run_op(6'h29, 32'h103, 32'h0,        0, 0,    32'h0,        0, 32'h0);
    run_op(6'h00, 32'h100, 32'h0,        0, 0,    32'h0,        0, 32'h0);
    run_op(6'h23, 32'h200, 32'h0,        3, 2,    32'h12345678, 0, 32'h12345678);
    run_op(6'h23, 32'h204, 32'h0,        0, -1,   32'h0,        0, 32'h0);
    run_op(6'h23, 32'h208, 32'h0,        1, TMO-1, 32'hCAFEF00D, 0, 32'hCAFEF00D);
    run_op(6'h2B, 32'h300, 32'h01020304, 1, 0,    32'h0,        3, 32'h0);
    run_op(6'h24, 32'h301, 32'h0,        0, 0,    32'hA5B6C7D8, 2, 32'h000000C7);

    // Reset while waiting for rvalid; the late rvalid must be dropped.
    bus_q.push_back('{we: 1'b0, addr: 32'h400, be: 4'hF, wdata: 32'h0});
    m_ir = {6'h23, 26'h0};
    m_ao = 32'h400;
    m_v2 = 32'h0;
    @(negedge clk);
    @(posedge clk); #1;
    bus.bus_gnt = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    bus.bus_gnt = 1'b0;
    @(negedge clk);
    check("wait_stall", 32'(stall), 32'd1);
    #2 reset = 1'b1;
    m_ir = '0;
    #2 reset = 1'b0;
    @(posedge clk); #1;
    bus.bus_rvalid = 1'b1;
    bus.bus_rdata  = 32'h77777777;
    @(negedge clk);
    check("rstw_stall", 32'(stall),       32'd0);
    check("rstw_req",   32'(bus.bus_req), 32'd0);
    @(posedge clk); #1;
    bus.bus_rvalid = 1'b0;
    @(negedge clk);
    check("rstw_ld_valid", 32'(ld_valid), 32'd0);
    check("rstw_ld_data",  ld_data,       32'd0);

    repeat (3) @(negedge clk);
    check("bus_q_empty", 32'(bus_q.size()), 32'd0);
    check("ld_q_empty",  32'(ld_q.size()),  32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
